// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: register-file geometry, instruction
// field positions, the default bubble word and the immediate sign-extender.
package decode_stage_pkg;

  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int INSTR_W   = 32;
  localparam int IMM_W     = 16;

  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  function automatic logic signed [RF_DATA_W-1:0] sign_ext(input logic signed [IMM_W-1:0] imm);
    return RF_DATA_W'(imm);
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32x32 register file with async clear and hardwired-zero r0.
// Define DECODE_BYPASS_EN to make a same-cycle write visible on the read ports.
module register_file
  import decode_stage_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [RF_ADDR_W-1:0] ra1,
  input  logic [RF_ADDR_W-1:0] ra2,
  input  logic                 we,
  input  logic [RF_ADDR_W-1:0] wa,
  input  logic [RF_DATA_W-1:0] wd,
  output logic [RF_DATA_W-1:0] rd1,
  output logic [RF_DATA_W-1:0] rd2
);

  logic [RF_DATA_W-1:0] regs [RF_DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [RF_DATA_W-1:0] read_port(input logic [RF_ADDR_W-1:0] addr);
    if (addr == '0) return '0;
`ifdef DECODE_BYPASS_EN
    if (we && (addr == wa)) return wd;
`endif
    return regs[addr];
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register, register-file reads, immediate
// extension, branch-target adder and early beq comparator (DECODE_BYPASS_EN optional).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic [INSTR_W-1:0]   InstrF,
  input  logic [RF_DATA_W-1:0] PCPlus4F,
  input  logic                 RegWriteW,
  input  logic [RF_ADDR_W-1:0] WriteRegW,
  input  logic [RF_DATA_W-1:0] ResultW,
  input  logic                 BranchD,
  input  logic                 ForwardAD,
  input  logic                 ForwardBD,
  input  logic [RF_DATA_W-1:0] ALUOutM,
  output logic [INSTR_W-1:0]   InstrD,
  output logic [RF_DATA_W-1:0] PCPlus4D,
  output logic [RF_DATA_W-1:0] RD1D,
  output logic [RF_DATA_W-1:0] RD2D,
  output logic [RF_ADDR_W-1:0] RsD,
  output logic [RF_ADDR_W-1:0] RtD,
  output logic [RF_ADDR_W-1:0] RdD,
  output logic [RF_DATA_W-1:0] SignImmD,
  output logic [RF_DATA_W-1:0] PCBranchD,
  output logic                 PCSrcD
);

  logic [RF_DATA_W-1:0] cmp_a, cmp_b;

  // IF/ID boundary: stall dominates flush so a held instruction is never lost
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      InstrD   <= NOP_INSTR;
      PCPlus4D <= '0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCPlus4D <= '0;
    end else begin
      InstrD   <= InstrF;
      PCPlus4D <= PCPlus4F;
    end
  end

  assign RsD = InstrD[RS_MSB:RS_LSB];
  assign RtD = InstrD[RT_MSB:RT_LSB];
  assign RdD = InstrD[RD_MSB:RD_LSB];

  register_file u_rf (
    .CLK (CLK),
    .RST (RST),
    .ra1 (RsD),
    .ra2 (RtD),
    .we  (RegWriteW),
    .wa  (WriteRegW),
    .wd  (ResultW),
    .rd1 (RD1D),
    .rd2 (RD2D)
  );

  always_comb begin
    SignImmD  = sign_ext(InstrD[IMM_MSB:IMM_LSB]);
    PCBranchD = PCPlus4D + (SignImmD << 2);
    cmp_a     = ForwardAD ? ALUOutM : RD1D;
    cmp_b     = ForwardBD ? ALUOutM : RD2D;
    PCSrcD    = BranchD & (cmp_a == cmp_b);
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, stall/flush, register file, bypass,
// branch target/compare and adder wrap.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        StallD, FlushD;
  logic [31:0] InstrF, PCPlus4F;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        BranchD, ForwardAD, ForwardBD;
  logic [31:0] ALUOutM;
  logic [31:0] InstrD, PCPlus4D, RD1D, RD2D, SignImmD, PCBranchD;
  logic [4:0]  RsD, RtD, RdD;
  logic        PCSrcD;

  int n_checks = 0;
  int n_fails  = 0;

  decode_stage dut (
    .CLK(CLK), .RST(RST), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .BranchD(BranchD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ALUOutM(ALUOutM),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .RD1D(RD1D), .RD2D(RD2D),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .PCBranchD(PCBranchD), .PCSrcD(PCSrcD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    InstrF = 32'h8C01_0004; PCPlus4F = 32'h0000_0004;
    RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'h0000_0077;
    BranchD = 1'b0; ForwardAD = 1'b0; ForwardBD = 1'b0; ALUOutM = '0;

    // Held in reset while clocking: nothing loads, writes are ignored
    tick(); tick();
    check("rst_instr", InstrD, 32'h0);
    check("rst_pc4",   PCPlus4D, 32'h0);
    check("rst_rd1",   RD1D, 32'h0);
    check("rst_rd2",   RD2D, 32'h0);
    check("rst_pcsrc", {31'b0, PCSrcD}, 32'h0);

    // Release between edges; the next edge loads InstrF and commits r1=0x77
    RST = 1'b1;
    tick();
    check("rel_instr", InstrD, 32'h8C01_0004);
    check("rel_pc4",   PCPlus4D, 32'h4);
    check("rel_rt",    {27'b0, RtD}, 32'd1);
    check("rel_wr_r1", RD2D, 32'h77);

    // Stall beats flush, then flush alone inserts a bubble
    RegWriteW = 1'b0;
    InstrF = 32'h2002_0005; PCPlus4F = 32'h8;
    tick();
    check("ld_instr", InstrD, 32'h2002_0005);
    StallD = 1'b1; FlushD = 1'b1; InstrF = 32'hFFFF_FFFF; PCPlus4F = 32'hC;
    tick();
    check("stall_instr", InstrD, 32'h2002_0005);
    check("stall_pc4",   PCPlus4D, 32'h8);
    StallD = 1'b0;
    tick();
    check("flush_instr", InstrD, 32'h0);
    check("flush_pc4",   PCPlus4D, 32'h0);
    FlushD = 1'b0;

    // r5 write then read via rs=5
    RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'hDEAD_BEEF;
    InstrF = 32'h00A0_0000;
    tick();
    RegWriteW = 1'b0;
    #1 check("rd_r5", RD1D, 32'hDEAD_BEEF);

    // r0 writes are discarded, even in the write cycle
    InstrF = 32'h0000_0000;
    tick();
    RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'h1234;
    #1 check("r0_same", RD1D, 32'h0);
    tick();
    RegWriteW = 1'b0;
    #1 check("r0_after", RD1D, 32'h0);

    // Same-cycle write/read of r7
    InstrF = 32'h00E0_0000;
    tick();
    RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h55;
    #1;
`ifdef DECODE_BYPASS_EN
    check("bypass_r7", RD1D, 32'h55);
`else
    check("bypass_r7", RD1D, 32'h0);
`endif
    tick();
    RegWriteW = 1'b0;
    #1 check("stored_r7", RD1D, 32'h55);

    // r1 = r2 = 9, then beq r1,r2,-2 at PC+4 = 0x100
    RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'd9;
    tick();
    WriteRegW = 5'd2;
    tick();
    RegWriteW = 1'b0;
    InstrF = 32'h1022_FFFE; PCPlus4F = 32'h100;
    tick();
    check("br_simm",   SignImmD, 32'hFFFF_FFFE);
    check("br_target", PCBranchD, 32'h0000_00F8);
    check("br_rd",     {27'b0, RdD}, 32'd31);
    check("br_nobr",   {31'b0, PCSrcD}, 32'h0);
    BranchD = 1'b1;
    #1 check("br_taken", {31'b0, PCSrcD}, 32'h1);
    ForwardAD = 1'b1; ALUOutM = 32'd8;
    #1 check("br_fwda_ne", {31'b0, PCSrcD}, 32'h0);
    ALUOutM = 32'd9;
    #1 check("br_fwda_eq", {31'b0, PCSrcD}, 32'h1);
    ForwardAD = 1'b0; ForwardBD = 1'b1; ALUOutM = 32'd10;
    #1 check("br_fwdb_ne", {31'b0, PCSrcD}, 32'h0);
    ForwardBD = 1'b0; BranchD = 1'b0;

    // Branch-target adder wraps modulo 2^32
    InstrF = 32'h0000_0001; PCPlus4F = 32'hFFFF_FFFC;
    tick();
    check("wrap_simm",   SignImmD, 32'h1);
    check("wrap_target", PCBranchD, 32'h0);

    // Asynchronous reset takes effect without a clock edge
    InstrF = 32'h1022_FFFE; PCPlus4F = 32'h200;
    tick();
    #2 RST = 1'b0;
    #1;
    check("arst_instr", InstrD, 32'h0);
    check("arst_pc4",   PCPlus4D, 32'h0);
    RST = 1'b1;
    tick();
    check("arst_r1_clr", RD1D, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: NOP_INSTR, default 32'h0000_0000, instruction word loaded into the IF/ID register on flush and reset.
REQ-002 CLK  in  1  single system clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-low.
REQ-004 StallD  in  1  hold IF/ID register contents.
REQ-005 FlushD  in  1  replace IF/ID contents with bubble.
REQ-006 InstrF  in  32  fetched instruction.
REQ-007 PCPlus4F  in  32  fetch PC+4.
REQ-008 RegWriteW  in  1  writeback write enable.
REQ-009 WriteRegW  in  5  writeback destination register.
REQ-010 ResultW  in  32  writeback data.
REQ-011 BranchD  in  1  beq decoded by control unit.
REQ-012 ForwardAD, ForwardBD  in  1 each  select ALUOutM for branch compare operand A/B.
REQ-013 ALUOutM  in  32  memory-stage ALU result.
REQ-014 InstrD  out  32  registered instruction.
REQ-015 PCPlus4D  out  32  registered PC+4.
REQ-016 RD1D, RD2D  out  32 each  register file reads at rs/rt.
REQ-017 RsD, RtD, RdD  out  5 each  InstrD[25:21], [20:16], [15:11].
REQ-018 SignImmD  out  32  sign-extended InstrD[15:0].
REQ-019 PCBranchD  out  32  branch target.
REQ-020 PCSrcD  out  1  branch taken.

Function
REQ-021 IF/ID register update priority per rising edge: FlushD&!StallD -> InstrD=NOP_INSTR, PCPlus4D=0; StallD -> hold (StallD wins over FlushD); else load InstrF/PCPlus4F.
REQ-022 Register file: 32 x 32-bit; combinational read at RsD/RtD; write ResultW to WriteRegW on rising edge when RegWriteW=1.
REQ-023 Register 0 always reads 0; writes to register 0 discarded.
REQ-024 SignImmD = {{16{InstrD[15]}}, InstrD[15:0]}.
REQ-025 PCBranchD = PCPlus4D + (SignImmD << 2), modulo 2^32, wrap-around ignored.
REQ-026 Compare operands: A = ForwardAD ? ALUOutM : RD1D; B = ForwardBD ? ALUOutM : RD2D.
REQ-027 PCSrcD = BranchD & (A == B), combinational, same cycle as InstrD valid.
REQ-028 Decode latency: one cycle from InstrF to InstrD-derived outputs.

Reset
REQ-029 RST low asynchronously forces InstrD=NOP_INSTR, PCPlus4D=0, all 32 registers to 0; hence RD1D=RD2D=0, PCSrcD=0 while BranchD derived from NOP.
REQ-030 RST released mid-write: the write at the first rising edge after deassertion is the first committed write.

Configuration
REQ-031 Macro DECODE_BYPASS_EN defined: read at address equal to nonzero WriteRegW with RegWriteW=1 returns ResultW same cycle (write-through).
REQ-032 DECODE_BYPASS_EN undefined: same-cycle read returns previously stored value; new value visible next cycle.

Structure
REQ-033 Shared package holds register-file depth/width constants, field bit positions (rs/rt/rd/imm), and NOP_INSTR default.
REQ-034 One sub-module, register_file, containing storage, reset clear, reg-0 rule and optional bypass; decode_stage holds IF/ID register, extender, branch adder, comparator.

Verification
REQ-035 Reset: RST=0 with InstrF=32'h8C01_0004 clocking -> InstrD=0, PCPlus4D=0, all reads 0; release -> next edge InstrD=32'h8C01_0004.
REQ-036 Stall+flush: StallD=1, FlushD=1 with InstrD=32'h2002_0005 -> InstrD holds 32'h2002_0005; StallD=0, FlushD=1 -> InstrD=0.
REQ-037 Write/read: write 32'hDEAD_BEEF to r5, then rs=5 -> RD1D=32'hDEAD_BEEF; write 32'h1234 to r0 -> r0 reads 0.
REQ-038 Bypass: same-cycle write r7=32'h55 and read rs=7 -> RD1D=32'h55 with DECODE_BYPASS_EN, old value (0 after reset) without.
REQ-039 Branch: PCPlus4D=32'h100, imm=16'hFFFE -> PCBranchD=32'hF8; BranchD=1, r1=r2=9 -> PCSrcD=1; ForwardAD=1, ALUOutM=8 -> PCSrcD=0.
REQ-040 Wrap: PCPlus4D=32'hFFFF_FFFC, imm=16'h0001 -> PCBranchD=32'h0000_0000.
